// File: rtl/riscv_br_pkg.sv
// Shared RV32I branch definitions: funct3 encodings, br_flags bit positions
// and the next-PC select encoding used by the PC stage.
package riscv_br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FLG_EQ  = 0;
  localparam int FLG_LT  = 1;
  localparam int FLG_LTU = 2;

  typedef enum logic [1:0] {
    SEL_PC4    = 2'd0,
    SEL_TARGET = 2'd1,
    SEL_TRAP   = 2'd2,
    SEL_HOLD   = 2'd3
  } next_pc_sel_t;

endpackage

// File: rtl/branch_pc_unit_br_cond.sv
// Branch condition evaluator: maps funct3 and the ALU compare flags to a
// taken condition; funct3 010/011 are not branches and flag illegal.
module br_cond
  import riscv_br_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [2:0] br_flags,
  output logic       cond,
  output logic       illegal
);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cond = br_flags[FLG_EQ];
      F3_BNE:  cond = ~br_flags[FLG_EQ];
      F3_BLT:  cond = br_flags[FLG_LT];
      F3_BGE:  cond = ~br_flags[FLG_LT];
      F3_BLTU: cond = br_flags[FLG_LTU];
      F3_BGEU: cond = ~br_flags[FLG_LTU];
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Next-PC stage: owns the architectural PC, picks branch/jump targets,
// traps on misaligned targets and counts retired and taken instructions.
module branch_pc_unit
  import riscv_br_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             instr_valid,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [2:0]       br_flags,
  input  logic [31:0]      alu_out,
  input  logic [31:0]      imm,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             taken,
  output logic             redirect_q,
  output logic             misalign_trap,
  output logic [31:0]      bad_target,
  output logic             illegal_br,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] br_taken_cnt
);

  if (RESET_PC[1:0] != 2'b00 || TRAP_VEC[1:0] != 2'b00) begin : g_bad_align
    $error("branch_pc_unit: RESET_PC and TRAP_VEC must be word-aligned");
  end

  logic         cond;
  logic         cond_illegal;
  logic [31:0]  target;
  logic         misaligned;
  next_pc_sel_t sel;

  br_cond u_br_cond (
    .funct3  (funct3),
    .br_flags(br_flags),
    .cond    (cond),
    .illegal (cond_illegal)
  );

  assign pc_plus4   = pc + 32'd4;
  assign illegal_br = is_branch & cond_illegal;
  // JALR wins over JAL/branch if the decoder ever raises more than one flag.
  assign target     = is_jalr ? {alu_out[31:1], 1'b0} : (pc + imm);
  assign taken      = instr_valid & (is_jal | is_jalr | (is_branch & cond));
  assign misaligned = taken & target[1];

  always_comb begin
    sel = SEL_PC4;
    if (stall)           sel = SEL_HOLD;
    else if (misaligned) sel = SEL_TRAP;
    else if (taken)      sel = SEL_TARGET;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= RESET_PC;
      redirect_q    <= 1'b0;
      misalign_trap <= 1'b0;
      bad_target    <= 32'd0;
      instret       <= '0;
      br_taken_cnt  <= '0;
    end else begin
      case (sel)
        SEL_HOLD: begin
          redirect_q    <= 1'b0;
          misalign_trap <= 1'b0;
        end
        SEL_TRAP: begin
          pc            <= TRAP_VEC;
          bad_target    <= target;
          misalign_trap <= 1'b1;
          redirect_q    <= 1'b0;
        end
        SEL_TARGET: begin
          pc            <= target;
          redirect_q    <= 1'b1;
          misalign_trap <= 1'b0;
          br_taken_cnt  <= br_taken_cnt + CNT_W'(1);
          instret       <= instret + CNT_W'(1);
        end
        default: begin
          pc            <= pc_plus4;
          redirect_q    <= 1'b0;
          misalign_trap <= 1'b0;
          if (instr_valid) instret <= instret + CNT_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: hand-computed PC/counter sequences,
// plus a narrow-counter instance sharing the same stimulus for wraparound.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        instr_valid;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [2:0]  funct3;
  logic [2:0]  br_flags;
  logic [31:0] alu_out;
  logic [31:0] imm;

  logic [31:0] pc, pc_plus4, bad_target;
  logic        taken, redirect_q, misalign_trap, illegal_br;
  logic [31:0] instret, br_taken_cnt;

  logic [31:0] pc_n, pc_plus4_n, bad_target_n;
  logic        taken_n, redirect_q_n, misalign_trap_n, illegal_br_n;
  logic [3:0]  instret_n, br_taken_cnt_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_pc_unit #(.RESET_PC(32'h0), .TRAP_VEC(32'h100), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .instr_valid(instr_valid),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .br_flags(br_flags), .alu_out(alu_out), .imm(imm),
    .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .redirect_q(redirect_q),
    .misalign_trap(misalign_trap), .bad_target(bad_target),
    .illegal_br(illegal_br), .instret(instret), .br_taken_cnt(br_taken_cnt)
  );

  branch_pc_unit #(.RESET_PC(32'h0), .TRAP_VEC(32'h100), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .stall(stall), .instr_valid(instr_valid),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .br_flags(br_flags), .alu_out(alu_out), .imm(imm),
    .pc(pc_n), .pc_plus4(pc_plus4_n), .taken(taken_n), .redirect_q(redirect_q_n),
    .misalign_trap(misalign_trap_n), .bad_target(bad_target_n),
    .illegal_br(illegal_br_n), .instret(instret_n), .br_taken_cnt(br_taken_cnt_n)
  );

  // At most one instruction-type flag may be raised at a time.
  always @(posedge clk) begin
    if (!reset)
      assert ($countones({is_branch, is_jal, is_jalr}) <= 1)
        else $error("more than one of is_branch/is_jal/is_jalr raised");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic plain();
    stall = 0; instr_valid = 1; is_branch = 0; is_jal = 0; is_jalr = 0;
    funct3 = 3'b000; br_flags = 3'b000; alu_out = 32'h0; imm = 32'h0;
  endtask

  task automatic do_reset();
    plain();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    plain();
    #3;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    n_checks++; if (instret !== 32'd0 || br_taken_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", instret, br_taken_cnt); end
    n_checks++; if (redirect_q !== 1'b0 || misalign_trap !== 1'b0 || bad_target !== 32'h0) begin n_fail++; $display("FAIL reset_flags got %b %b %h exp 0 0 0", redirect_q, misalign_trap, bad_target); end
    step();
    reset = 0;
    step();
    n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL fetch1_pc got %h exp %h", pc, 32'h4); end
    step();
    n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL fetch2_pc got %h exp %h", pc, 32'h8); end
    step();
    n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL fetch3_pc got %h exp %h", pc, 32'hC); end
    n_checks++; if (instret !== 32'd3 || br_taken_cnt !== 32'd0) begin n_fail++; $display("FAIL fetch_cnt got %0d/%0d exp 3/0", instret, br_taken_cnt); end
  endtask

  task automatic test_beq();
    step();  // pc 0x10, instret 4
    is_branch = 1; funct3 = 3'b000; br_flags = 3'b001; imm = 32'h20;
    #1;
    n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken_comb got %b exp 1", taken); end
    n_checks++; if (pc_plus4 !== 32'h14) begin n_fail++; $display("FAIL pc_plus4 got %h exp %h", pc_plus4, 32'h14); end
    step();
    n_checks++; if (pc !== 32'h30) begin n_fail++; $display("FAIL beq_pc got %h exp %h", pc, 32'h30); end
    n_checks++; if (redirect_q !== 1'b1) begin n_fail++; $display("FAIL beq_redirect got %b exp 1", redirect_q); end
    n_checks++; if (br_taken_cnt !== 32'd1 || instret !== 32'd5) begin n_fail++; $display("FAIL beq_cnt got %0d/%0d exp 1/5", br_taken_cnt, instret); end
    plain();
    step();
    n_checks++; if (pc !== 32'h34 || redirect_q !== 1'b0) begin n_fail++; $display("FAIL beq_pulse_end got %h %b exp 34 0", pc, redirect_q); end
    is_branch = 1; funct3 = 3'b000; br_flags = 3'b000; imm = 32'h20;
    #1;
    n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL beq_nt_comb got %b exp 0", taken); end
    step();
    n_checks++; if (pc !== 32'h38 || redirect_q !== 1'b0) begin n_fail++; $display("FAIL beq_nt_pc got %h %b exp 38 0", pc, redirect_q); end
  endtask

  task automatic test_bgeu_blt();
    is_branch = 1; funct3 = 3'b111; br_flags = 3'b100; imm = 32'h80;
    step();
    n_checks++; if (pc !== 32'h3C) begin n_fail++; $display("FAIL bgeu_nt_pc got %h exp %h", pc, 32'h3C); end
    plain();
    step();  // pc 0x40, instret 9
    is_branch = 1; funct3 = 3'b100; br_flags = 3'b010; imm = 32'hFFFF_FFF8;
    step();
    n_checks++; if (pc !== 32'h38) begin n_fail++; $display("FAIL blt_pc got %h exp %h", pc, 32'h38); end
    n_checks++; if (br_taken_cnt !== 32'd2 || instret !== 32'd10) begin n_fail++; $display("FAIL blt_cnt got %0d/%0d exp 2/10", br_taken_cnt, instret); end
  endtask

  task automatic test_jalr();
    plain();
    is_jalr = 1; alu_out = 32'h1235;
    step();
    n_checks++; if (pc !== 32'h1234 || redirect_q !== 1'b1) begin n_fail++; $display("FAIL jalr_pc got %h %b exp 1234 1", pc, redirect_q); end
    alu_out = 32'h1006;
    step();
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL trap_pc got %h exp %h", pc, 32'h100); end
    n_checks++; if (misalign_trap !== 1'b1 || redirect_q !== 1'b0) begin n_fail++; $display("FAIL trap_pulse got %b %b exp 1 0", misalign_trap, redirect_q); end
    n_checks++; if (bad_target !== 32'h1006) begin n_fail++; $display("FAIL trap_bad got %h exp %h", bad_target, 32'h1006); end
    n_checks++; if (instret !== 32'd11 || br_taken_cnt !== 32'd3) begin n_fail++; $display("FAIL trap_cnt got %0d/%0d exp 11/3", instret, br_taken_cnt); end
    plain();
    step();
    n_checks++; if (pc !== 32'h104 || misalign_trap !== 1'b0 || bad_target !== 32'h1006) begin n_fail++; $display("FAIL trap_after got %h %b %h exp 104 0 1006", pc, misalign_trap, bad_target); end
  endtask

  task automatic test_stall();
    is_jal = 1; imm = 32'h40;
    step();
    n_checks++; if (pc !== 32'h144 || redirect_q !== 1'b1) begin n_fail++; $display("FAIL jal_pc got %h %b exp 144 1", pc, redirect_q); end
    stall = 1;
    step();
    n_checks++; if (pc !== 32'h144 || redirect_q !== 1'b0 || misalign_trap !== 1'b0) begin n_fail++; $display("FAIL stall_hold got %h %b %b exp 144 0 0", pc, redirect_q, misalign_trap); end
    n_checks++; if (instret !== 32'd13 || br_taken_cnt !== 32'd4) begin n_fail++; $display("FAIL stall_cnt got %0d/%0d exp 13/4", instret, br_taken_cnt); end
    stall = 0;
    step();
    n_checks++; if (pc !== 32'h184 || redirect_q !== 1'b1) begin n_fail++; $display("FAIL unstall_pc got %h %b exp 184 1", pc, redirect_q); end
    n_checks++; if (instret !== 32'd14 || br_taken_cnt !== 32'd5) begin n_fail++; $display("FAIL unstall_cnt got %0d/%0d exp 14/5", instret, br_taken_cnt); end
  endtask

  task automatic test_illegal();
    plain();
    is_branch = 1; funct3 = 3'b010; br_flags = 3'b001; imm = 32'h20;
    #1;
    n_checks++; if (illegal_br !== 1'b1 || taken !== 1'b0) begin n_fail++; $display("FAIL illegal_comb got %b %b exp 1 0", illegal_br, taken); end
    step();
    n_checks++; if (pc !== 32'h188 || instret !== 32'd15 || br_taken_cnt !== 32'd5) begin n_fail++; $display("FAIL illegal_seq got %h %0d %0d exp 188 15 5", pc, instret, br_taken_cnt); end
    plain();
    instr_valid = 0;
    step();
    n_checks++; if (pc !== 32'h18C || instret !== 32'd15) begin n_fail++; $display("FAIL bubble got %h %0d exp 18c 15", pc, instret); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) step();
    n_checks++; if (instret_n !== 4'd1) begin n_fail++; $display("FAIL wrap_instret got %0d exp 1", instret_n); end
    n_checks++; if (instret !== 32'd17 || pc !== 32'h44) begin n_fail++; $display("FAIL wrap_wide got %0d %h exp 17 44", instret, pc); end
  endtask

  task automatic test_async_reset();
    stall = 1;
    step();
    #2;
    reset = 1;
    #1;
    n_checks++; if (pc !== 32'h0 || instret !== 32'd0) begin n_fail++; $display("FAIL async_reset got %h %0d exp 0 0", pc, instret); end
    plain();
    step();
    reset = 0;
    step();
    n_checks++; if (pc !== 32'h4 || instret !== 32'd1) begin n_fail++; $display("FAIL post_reset got %h %0d exp 4 1", pc, instret); end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_bgeu_blt();
    test_jalr();
    test_stall();
    test_illegal();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
Next-PC stage directly downstream of the ALU in the single-cycle core. It consumes the ALU's br_flags {ltu, lt, eq} and alu_out (the JALR target, rs1+imm) and evaluates RV32I branch conditions. It owns the architectural PC register, selects the next PC, and traps on misaligned targets. It also keeps instruction-retired and taken-branch counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned-target trap.
CNT_W, 32, width of the instret and taken-branch counters.

Ports:
clk  input  1  core clock, rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  hold PC and counters this cycle.
instr_valid  input  1  current instruction retires this cycle.
is_branch  input  1  conditional branch (B-type).
is_jal  input  1  JAL.
is_jalr  input  1  JALR.
funct3  input  3  branch condition select.
br_flags  input  3  {ltu, lt, eq} from the ALU for rs1 vs rs2.
alu_out  input  32  JALR target (rs1+imm).
imm  input  32  sign-extended B/J offset.
pc  output  32  current PC (register).
pc_plus4  output  32  pc+4, combinational; used as the link value.
taken  output  1  combinational: a redirect is selected this cycle.
redirect_q  output  1  registered one-cycle pulse after a taken redirect.
misalign_trap  output  1  registered one-cycle pulse after a trap.
bad_target  output  32  target that caused the last trap; held until the next trap.
illegal_br  output  1  combinational: is_branch with funct3 010 or 011.
instret  output  CNT_W  retired-instruction count.
br_taken_cnt  output  CNT_W  taken-branch/jump count.

Behaviour:
- Reset (asynchronous, active-high): pc=RESET_PC; redirect_q=0; misalign_trap=0; bad_target=0; instret=0; br_taken_cnt=0.
- Branch condition by funct3:
  - 000 eq; 001 ~eq.
  - 100 lt; 101 ~lt.
  - 110 ltu; 111 ~ltu.
  - 010/011: not taken, illegal_br=1.
- Target selection:
  - branch/JAL target = pc+imm, 32-bit wraparound.
  - JALR target = {alu_out[31:1],1'b0}.
- taken = instr_valid & (is_jal | is_jalr | (is_branch & cond)).
- Misaligned: taken & target[1]==1 (no C extension).
- Next-PC priority at the clock edge: reset > stall > misaligned > taken > pc+4.
  - stall=1: pc, counters and bad_target hold; redirect_q and misalign_trap clear to 0.
  - instr_valid=0 without stall: pc advances by +4 (fetch bubble); counters do not increment.
  - misaligned: pc<=TRAP_VEC; bad_target<=target; misalign_trap<=1; instret does not increment; br_taken_cnt does not increment; redirect_q<=0.
  - taken and aligned: pc<=target; redirect_q<=1; br_taken_cnt++; instret++.
  - otherwise: pc<=pc+4; instret++ if instr_valid.
- Illegal branch: treated as not taken and still retires (instret++); trap handling of illegal_br belongs to the decoder.
- More than one of is_branch/is_jal/is_jalr set: illegal input. Design priority is jalr > jal > branch, and the bench asserts this never occurs.
- Counters wrap modulo 2^CNT_W with no saturation.
- pc[1:0] is always 00 when RESET_PC and TRAP_VEC are word-aligned; an elaboration assertion checks both.
- Reset asserted mid-stall or mid-trap overrides everything asynchronously; the first cycle after deassertion behaves as a normal fetch from RESET_PC.

Decomposition:
- Package riscv_br_pkg holds:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU;
  - br_flags bit indices FLG_EQ=0, FLG_LT=1, FLG_LTU=2;
  - a next_pc_sel_t enum {SEL_PC4, SEL_TARGET, SEL_TRAP, SEL_HOLD}.
- One combinational sub-module, br_cond: inputs funct3, br_flags; outputs cond and illegal. It is reused later by the pipelined core.
- The rest is the top module: target adder, select logic, registers and counters.

Test Plan:
- Reset release: RESET_PC=0, then 3 cycles instr_valid=1 with no branch -> pc 0,4,8,C; instret=3; br_taken_cnt=0.
- BEQ taken: pc=0x10, is_branch, funct3=000, br_flags=001, imm=0x20 -> next pc=0x30; redirect_q=1 for one cycle; br_taken_cnt=1. Same with br_flags=000 -> pc=0x14.
- BGEU/BLT: funct3=111 with ltu=1 -> pc+4; funct3=100 with lt=1, imm=-8 at pc=0x40 -> pc=0x38.
- JALR aligned and misaligned:
  - alu_out=0x1235 -> target 0x1234 has bit1=0? No: 0x1234 has bit1=0, so pc=0x1234.
  - alu_out=0x1006 -> target 0x1006 misaligned -> pc=TRAP_VEC 0x100; misalign_trap pulse; bad_target=0x1006; instret unchanged.
- Stall: assert stall during a taken JAL -> pc, instret and br_taken_cnt hold; no pulses. Deassert -> redirect occurs.
- Wrap and reset: CNT_W=4, 17 retirements -> instret=1. Assert reset mid-sequence asynchronously (between edges) -> pc=RESET_PC immediately.
- Illegal branch: funct3=010 -> illegal_br=1; not taken; pc+4; instret++.
